// File: rtl/apb_timeout_slice.sv
// apb_timeout_slice: APB pass-through slice that bounds downstream ACCESS time
// and answers upstream with PSLVERR when the peripheral never becomes ready.
module apb_timeout_slice #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  slv_psel_i,
   input  logic                  slv_penable_i,
   input  logic                  slv_pwrite_i,
   input  logic [ADDR_WIDTH-1:0] slv_paddr_i,
   input  logic [DATA_WIDTH-1:0] slv_pwdata_i,
   output logic [DATA_WIDTH-1:0] slv_prdata_o,
   output logic                  slv_pready_o,
   output logic                  slv_pslverr_o,
   output logic                  mst_psel_o,
   output logic                  mst_penable_o,
   output logic                  mst_pwrite_o,
   output logic [ADDR_WIDTH-1:0] mst_paddr_o,
   output logic [DATA_WIDTH-1:0] mst_pwdata_o,
   input  logic [DATA_WIDTH-1:0] mst_prdata_i,
   input  logic                  mst_pready_i,
   input  logic                  mst_pslverr_i,
   output logic                  timeout_o,
   output logic [15:0]           timeout_cnt_o,
   input  logic                  timeout_clr_i
);
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("apb_timeout_slice: TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_write;
   logic [CW-1:0]         r_wait;
   logic [DATA_WIDTH-1:0] r_prdata;
   logic                  r_pslverr;
   logic                  r_to;
   logic [15:0]           r_tcnt;
   logic                  w_expire;
   logic                  w_resp;
   logic                  w_to_inc;
   logic                  w_unused;

   // upstream PENABLE carries no information this slice needs
   assign w_unused = slv_penable_i;

   assign w_expire = !mst_pready_i && (r_wait == CW'(TIMEOUT_CYCLES - 1));
   assign w_resp   = (r_state == RESP);
   assign w_to_inc = w_resp && r_to;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = slv_psel_i ? SETUP : IDLE;
         SETUP:   w_next = ACCESS;
         ACCESS:  w_next = (mst_pready_i || w_expire) ? RESP : ACCESS;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_write   <= 1'b0;
         r_wait    <= '0;
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
         r_to      <= 1'b0;
      end else begin
         if (r_state == IDLE && slv_psel_i) begin
            r_addr  <= slv_paddr_i;
            r_wdata <= slv_pwdata_i;
            r_write <= slv_pwrite_i;
            r_to    <= 1'b0;
         end
         if (r_state == SETUP) r_wait <= '0;
         // a ready peripheral on the last allowed cycle beats the timeout
         if (r_state == ACCESS) begin
            if (mst_pready_i) begin
               r_prdata  <= mst_prdata_i;
               r_pslverr <= mst_pslverr_i;
            end else if (w_expire) begin
               r_prdata  <= '0;
               r_pslverr <= 1'b1;
               r_to      <= 1'b1;
            end else begin
               r_wait <= r_wait + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                               r_tcnt <= '0;
      else if (timeout_clr_i)                    r_tcnt <= {15'd0, w_to_inc};
      else if (w_to_inc && r_tcnt != 16'hFFFF)   r_tcnt <= r_tcnt + 16'd1;
   end

   assign mst_psel_o    = (r_state == SETUP) || (r_state == ACCESS);
   assign mst_penable_o = (r_state == ACCESS);
   assign mst_paddr_o   = r_addr;
   assign mst_pwdata_o  = r_wdata;
   assign mst_pwrite_o  = r_write;
   assign slv_pready_o  = w_resp;
   assign slv_prdata_o  = w_resp ? r_prdata : '0;
   assign slv_pslverr_o = w_resp && r_pslverr;
   assign timeout_o     = w_to_inc;
   assign timeout_cnt_o = r_tcnt;
endmodule

// File: tb/tb_apb_timeout_slice.sv
// tb_apb_timeout_slice: randomized and directed checks of the timeout slice
// against a transfer-level model (latency, returned data, timeout count).
module tb_apb_timeout_slice;
   localparam int T = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        slv_psel_i = 1'b0;
   logic        slv_penable_i = 1'b0;
   logic        slv_pwrite_i = 1'b0;
   logic [31:0] slv_paddr_i = '0;
   logic [31:0] slv_pwdata_i = '0;
   logic [31:0] slv_prdata_o;
   logic        slv_pready_o;
   logic        slv_pslverr_o;
   logic        mst_psel_o;
   logic        mst_penable_o;
   logic        mst_pwrite_o;
   logic [31:0] mst_paddr_o;
   logic [31:0] mst_pwdata_o;
   logic [31:0] mst_prdata_i = '0;
   logic        mst_pready_i = 1'b0;
   logic        mst_pslverr_i = 1'b0;
   logic        timeout_o;
   logic [15:0] timeout_cnt_o;
   logic        timeout_clr_i = 1'b0;

   int total = 0;
   int bad = 0;
   int m_cnt = 0;

   always #5 clk_i = ~clk_i;

   apb_timeout_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_psel_i(slv_psel_i), .slv_penable_i(slv_penable_i), .slv_pwrite_i(slv_pwrite_i),
      .slv_paddr_i(slv_paddr_i), .slv_pwdata_i(slv_pwdata_i), .slv_prdata_o(slv_prdata_o),
      .slv_pready_o(slv_pready_o), .slv_pslverr_o(slv_pslverr_o),
      .mst_psel_o(mst_psel_o), .mst_penable_o(mst_penable_o), .mst_pwrite_o(mst_pwrite_o),
      .mst_paddr_o(mst_paddr_o), .mst_pwdata_o(mst_pwdata_o), .mst_prdata_i(mst_prdata_i),
      .mst_pready_i(mst_pready_i), .mst_pslverr_i(mst_pslverr_i),
      .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o), .timeout_clr_i(timeout_clr_i)
   );

   // One upstream transfer; the peripheral stalls for w cycles before ready.
   // Model: w >= T times out and answers at N+T+2 with 0/err, else at N+w+3.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int w, input logic [31:0] rd, input logic err,
                       input logic drop, input logic clr, input string tag);
      bit          exp_to;
      int          exp_lat;
      bit          got;
      int          c;
      logic [31:0] exp_rd;
      @(negedge clk_i);
      timeout_clr_i = 1'b0;
      total++;
      if (timeout_cnt_o !== 16'(m_cnt)) begin
         bad++;
         $display("FAIL %s cnt_before got=%h want=%h", tag, timeout_cnt_o, 16'(m_cnt));
      end
      total++;
      if (slv_pready_o !== 1'b0 || mst_psel_o !== 1'b0 || timeout_o !== 1'b0) begin
         bad++;
         $display("FAIL %s idle got pready=%b psel=%b to=%b want 0", tag, slv_pready_o, mst_psel_o, timeout_o);
      end
      slv_psel_i = 1'b1; slv_penable_i = 1'b0;
      slv_pwrite_i = wr; slv_paddr_i = addr; slv_pwdata_i = wdata;
      exp_to  = (w >= T);
      exp_lat = exp_to ? T + 2 : w + 3;
      exp_rd  = exp_to ? 32'd0 : rd;
      got = 1'b0;
      c = 0;
      while (!got && c < T + 8) begin
         @(negedge clk_i);
         c++;
         if (drop) slv_psel_i = 1'b0;
         else slv_penable_i = 1'b1;
         if (slv_pready_o === 1'b1) begin
            got = 1'b1;
            total++;
            if (c != exp_lat) begin
               bad++;
               $display("FAIL %s latency got=%0d want=%0d", tag, c, exp_lat);
            end
            total++;
            if (slv_prdata_o !== exp_rd || slv_pslverr_o !== (exp_to ? 1'b1 : err)) begin
               bad++;
               $display("FAIL %s resp got data=%h err=%b want data=%h err=%b", tag,
                        slv_prdata_o, slv_pslverr_o, exp_rd, exp_to ? 1'b1 : err);
            end
            total++;
            if (timeout_o !== exp_to) begin
               bad++;
               $display("FAIL %s timeout_pulse got=%b want=%b", tag, timeout_o, exp_to);
            end
            total++;
            if (mst_psel_o !== 1'b0 || mst_penable_o !== 1'b0 || mst_paddr_o !== addr ||
                mst_pwdata_o !== wdata || mst_pwrite_o !== wr) begin
               bad++;
               $display("FAIL %s mst_in_resp got psel=%b en=%b addr=%h wd=%h wr=%b want 0 0 %h %h %b",
                        tag, mst_psel_o, mst_penable_o, mst_paddr_o, mst_pwdata_o, mst_pwrite_o, addr, wdata, wr);
            end
            if (clr) timeout_clr_i = 1'b1;
            m_cnt = clr ? int'(exp_to) : (exp_to && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
         end else begin
            total++;
            if (mst_psel_o !== 1'b1 || mst_penable_o !== (c != 1) || mst_paddr_o !== addr ||
                mst_pwdata_o !== wdata || mst_pwrite_o !== wr || slv_prdata_o !== 32'd0 ||
                slv_pslverr_o !== 1'b0 || timeout_o !== 1'b0) begin
               bad++;
               $display("FAIL %s cycle%0d got psel=%b en=%b addr=%h wd=%h wr=%b rd=%h err=%b to=%b want en=%b addr=%h wd=%h wr=%b",
                        tag, c, mst_psel_o, mst_penable_o, mst_paddr_o, mst_pwdata_o, mst_pwrite_o,
                        slv_prdata_o, slv_pslverr_o, timeout_o, c != 1, addr, wdata, wr);
            end
            mst_pready_i  = (c == w + 2);
            mst_prdata_i  = (c == w + 2) ? rd : $urandom;
            mst_pslverr_i = (c == w + 2) ? err : 1'($urandom_range(0, 1));
         end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL %s no_response got none want pready at %0d", tag, exp_lat);
      end
      slv_psel_i = 1'b0; slv_penable_i = 1'b0; mst_pready_i = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk_i);
      total++;
      if ({slv_pready_o, slv_pslverr_o, timeout_o, mst_psel_o, mst_penable_o, mst_pwrite_o} !== 6'd0 ||
          slv_prdata_o !== 32'd0 || mst_paddr_o !== 32'd0 || mst_pwdata_o !== 32'd0 || timeout_cnt_o !== 16'd0) begin
         bad++;
         $display("FAIL reset_state got pready=%b psel=%b addr=%h cnt=%h want all 0", slv_pready_o, mst_psel_o, mst_paddr_o, timeout_cnt_o);
      end
      rst_ni = 1'b1;
   endtask

   task automatic test_read;
      xfer(1'b0, 32'h1A10_1000, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, "read");
   endtask

   task automatic test_write_wait;
      xfer(1'b1, 32'h1A10_2004, 32'h0000_00A5, 3, 32'h1234_5678, 1'b1, 1'b0, 1'b0, "write_wait3");
   endtask

   task automatic test_timeout;
      xfer(1'b0, 32'h1A10_3000, 32'h0, T + 10, 32'h0, 1'b0, 1'b0, 1'b0, "timeout");
      xfer(1'b0, 32'h1A10_3004, 32'h0, T - 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, "last_cycle_ready");
      xfer(1'b1, 32'h1A10_3008, 32'h55, T, 32'h0, 1'b0, 1'b0, 1'b0, "ready_too_late");
   endtask

   task automatic test_back_to_back;
      xfer(1'b1, 32'h0000_0100, 32'h1111_1111, 0, 32'h0, 1'b0, 1'b0, 1'b0, "b2b0");
      xfer(1'b0, 32'h0000_0104, 32'h2222_2222, 1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, "b2b1");
      xfer(1'b0, 32'h0000_0108, 32'h3333_3333, 0, 32'hAAAA_0002, 1'b1, 1'b0, 1'b0, "b2b2");
   endtask

   task automatic test_drop;
      xfer(1'b1, 32'h0000_0200, 32'h4444_4444, 2, 32'h0, 1'b0, 1'b1, 1'b0, "psel_drop");
      repeat (3) begin
         @(negedge clk_i);
         total++;
         if (slv_pready_o !== 1'b0 || mst_psel_o !== 1'b0) begin
            bad++;
            $display("FAIL psel_drop_extra got pready=%b psel=%b want 0 0", slv_pready_o, mst_psel_o);
         end
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk_i);
      slv_psel_i = 1'b1; slv_pwrite_i = 1'b1; slv_paddr_i = 32'h0000_0300; slv_pwdata_i = 32'h7777_7777;
      repeat (4) begin
         @(negedge clk_i);
         slv_penable_i = 1'b1;
         mst_pready_i = 1'b0;
      end
      rst_ni = 1'b0;
      #1;
      total++;
      if ({slv_pready_o, slv_pslverr_o, timeout_o, mst_psel_o, mst_penable_o, mst_pwrite_o} !== 6'd0 ||
          slv_prdata_o !== 32'd0 || mst_paddr_o !== 32'd0 || mst_pwdata_o !== 32'd0 || timeout_cnt_o !== 16'd0) begin
         bad++;
         $display("FAIL reset_mid got psel=%b en=%b wr=%b addr=%h wd=%h cnt=%h want all 0",
                  mst_psel_o, mst_penable_o, mst_pwrite_o, mst_paddr_o, mst_pwdata_o, timeout_cnt_o);
      end
      m_cnt = 0;
      slv_psel_i = 1'b0; slv_penable_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (T + 4) begin
         @(negedge clk_i);
         total++;
         if (slv_pready_o !== 1'b0 || mst_psel_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_abandon got pready=%b psel=%b want 0 0", slv_pready_o, mst_psel_o);
         end
      end
      xfer(1'b0, 32'h0000_0304, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_saturate;
      @(negedge clk_i);
      force dut.r_tcnt = 16'hFFFE;
      @(negedge clk_i);
      release dut.r_tcnt;
      m_cnt = 65534;
      xfer(1'b0, 32'h0000_0400, 32'h0, T + 1, 32'h0, 1'b0, 1'b0, 1'b0, "sat_to_ffff");
      xfer(1'b0, 32'h0000_0404, 32'h0, T + 2, 32'h0, 1'b0, 1'b0, 1'b0, "sat_hold");
      xfer(1'b0, 32'h0000_0408, 32'h0, T + 3, 32'h0, 1'b0, 1'b0, 1'b1, "clr_with_timeout");
      xfer(1'b0, 32'h0000_040C, 32'h0, 0, 32'h9, 1'b0, 1'b0, 1'b0, "after_clr");
      @(negedge clk_i);
      timeout_clr_i = 1'b1;
      @(negedge clk_i);
      timeout_clr_i = 1'b0;
      m_cnt = 0;
      total++;
      if (timeout_cnt_o !== 16'd0) begin
         bad++;
         $display("FAIL clr_alone got=%h want=0000", timeout_cnt_o);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         int w;
         w = ($urandom_range(0, 7) == 0) ? T - 1 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
         xfer(1'($urandom_range(0, 1)), $urandom, $urandom, w, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0), "random");
      end
   endtask

   initial begin
      test_reset;
      test_read;
      test_write_wait;
      test_timeout;
      test_back_to_back;
      test_drop;
      test_reset_mid;
      test_timeout;
      test_saturate;
      test_random;
      @(negedge clk_i);
      timeout_clr_i = 1'b0;
      total++;
      if (timeout_cnt_o !== 16'(m_cnt)) begin
         bad++;
         $display("FAIL final_cnt got=%h want=%h", timeout_cnt_o, 16'(m_cnt));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
